// File: rtl/equiv_pkg.sv
// Shared definitions for the five-input equivalence checker.
//   IDX_W      : width of the input index {a,b,c,d,e}
//   NUM_COMBOS : number of distinct input combinations (coverage width)
//   in_vec_t   : packed input vector, a is the MSB, e the LSB
package equiv_pkg;
    localparam int IDX_W      = 5;
    localparam int NUM_COMBOS = 32;

    typedef logic [IDX_W-1:0] in_vec_t;
endpackage

// File: rtl/equiv_checker_if.sv
// Bus bundle for equiv_checker.
//   a..e            : function inputs (driven by the master / stimulus side)
//   m_question      : registered reference-form result
//   m_answer        : registered minimised-form result
//   mismatch        : registered disagreement flag for the current sample
//   mismatch_sticky : set on first mismatch, held until reset
//   mismatch_count  : saturating count of mismatching samples
//   coverage        : one bit per input combination seen
interface equiv_checker_if
    import equiv_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic                  a;
    logic                  b;
    logic                  c;
    logic                  d;
    logic                  e;
    logic                  m_question;
    logic                  m_answer;
    logic                  mismatch;
    logic                  mismatch_sticky;
    logic [CNT_W-1:0]      mismatch_count;
    logic [NUM_COMBOS-1:0] coverage;

    modport master (
        output a, b, c, d, e,
        input  m_question, m_answer, mismatch, mismatch_sticky,
               mismatch_count, coverage
    );

    modport slave (
        input  a, b, c, d, e,
        output m_question, m_answer, mismatch, mismatch_sticky,
               mismatch_count, coverage
    );
endinterface

// File: rtl/equiv_funcs.sv
// Combinational evaluation of the two implementations of the function.
//   a..e : inputs
//   q    : reference (unsimplified) sum-of-products form
//   n    : hand-minimised form
// The two forms are written independently on purpose so that a fault in
// either one shows up as a disagreement downstream.
module equiv_funcs (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    output logic q,
    output logic n
);
    assign q = a | (~a & b & c) | (~a & b & ~c & d) | (~a & e);
    assign n = a | e | (b & (c | d));
endmodule

// File: rtl/equiv_checker.sv
// Registered equivalence checker for one five-input Boolean function.
// Samples a..e directly every clock, registers both implementations'
// results, flags and counts disagreements and records input coverage.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset; a sample taken in a reset cycle
//         is discarded (not counted, not covered)
//   bus : equiv_checker_if slave (inputs a..e, all registered outputs)
module equiv_checker
    import equiv_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    equiv_checker_if.slave  bus
);
    logic    q_c;
    logic    n_c;
    logic    diff_c;
    in_vec_t idx_c;

    logic                  m_question_q;
    logic                  m_answer_q;
    logic                  mismatch_q;
    logic                  sticky_q;
    logic [CNT_W-1:0]      count_q;
    logic [NUM_COMBOS-1:0] coverage_q;

    equiv_funcs u_funcs (
        .a (bus.a),
        .b (bus.b),
        .c (bus.c),
        .d (bus.d),
        .e (bus.e),
        .q (q_c),
        .n (n_c)
    );

    assign diff_c = q_c ^ n_c;
    assign idx_c  = {bus.a, bus.b, bus.c, bus.d, bus.e};

    always_ff @(posedge clk) begin
        if (rst) begin
            m_question_q <= 1'b0;
            m_answer_q   <= 1'b0;
            mismatch_q   <= 1'b0;
            sticky_q     <= 1'b0;
            count_q      <= '0;
            coverage_q   <= '0;
        end else begin
            m_question_q       <= q_c;
            m_answer_q         <= n_c;
            mismatch_q         <= diff_c;
            coverage_q[idx_c]  <= 1'b1;
            if (diff_c) begin
                sticky_q <= 1'b1;
                // Saturate at all-ones rather than wrap.
                if (count_q != '1)
                    count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.m_question      = m_question_q;
    assign bus.m_answer        = m_answer_q;
    assign bus.mismatch        = mismatch_q;
    assign bus.mismatch_sticky = sticky_q;
    assign bus.mismatch_count  = count_q;
    assign bus.coverage        = coverage_q;
endmodule

// File: tb/tb_equiv_checker.sv
// Self-checking bench for equiv_checker with a behavioural model of the
// function, mismatch tracking and coverage mask.
module tb_equiv_checker;
    localparam int CNT_W = 8;

    logic clk;
    logic rst;

    equiv_checker_if #(.CNT_W(CNT_W)) bus ();

    equiv_checker #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic             exp_mq;
    logic             exp_ma;
    logic             exp_mm;
    logic             exp_ms;
    logic [CNT_W-1:0] exp_cnt;
    logic [31:0]      exp_cov;

    logic [CNT_W+35:0] obs_v;
    logic [CNT_W+35:0] exp_v;

    // Function as stated by the reference sum-of-products rule, using
    // plain integer arithmetic on the index.
    function automatic logic ref_f(input int idx);
        int a, b, c, d, e;
        a = (idx >> 4) & 1;
        b = (idx >> 3) & 1;
        c = (idx >> 2) & 1;
        d = (idx >> 1) & 1;
        e = idx & 1;
        return (a == 1) || (a == 0 && b == 1 && c == 1) ||
               (a == 0 && b == 1 && c == 0 && d == 1) || (a == 0 && e == 1);
    endfunction

    // Apply one sample, clock it, update the model.
    task automatic drive(input int idx, input logic r, input logic fault);
        logic q;
        logic n;
        logic [4:0] iv;
        iv = idx[4:0];
        {bus.a, bus.b, bus.c, bus.d, bus.e} = iv;
        rst = r;
        q = ref_f(idx);
        if (fault) begin
            if (q) force dut.n_c = 1'b0;
            else   force dut.n_c = 1'b1;
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_mq = 0; exp_ma = 0; exp_mm = 0; exp_ms = 0;
            exp_cnt = '0; exp_cov = '0;
        end else begin
            n = fault ? ~q : q;
            exp_mq = q;
            exp_ma = n;
            exp_mm = q ^ n;
            if (q ^ n) begin
                exp_ms = 1'b1;
                if (int'(exp_cnt) < (1 << CNT_W) - 1) exp_cnt = exp_cnt + 1'b1;
            end
            exp_cov = exp_cov | (32'd1 << idx);
        end
        exp_v = {exp_mq, exp_ma, exp_mm, exp_ms, exp_cnt, exp_cov};
        obs_v = {bus.m_question, bus.m_answer, bus.mismatch,
                 bus.mismatch_sticky, bus.mismatch_count, bus.coverage};
    endtask

    task automatic test_reset();
        drive(16, 1'b1, 1'b0);
        n_checks++;
        if (obs_v !== {(CNT_W+36){1'b0}}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", obs_v);
        end
        drive(16, 1'b0, 1'b0);
        n_checks++;
        if (bus.m_question !== 1'b1 || bus.m_answer !== 1'b1 || bus.mismatch !== 1'b0 ||
            bus.coverage !== 32'h0001_0000) begin
            n_fail++;
            $display("FAIL first_sample: got mq=%b ma=%b mm=%b cov=%h want 1 1 0 00010000",
                     bus.m_question, bus.m_answer, bus.mismatch, bus.coverage);
        end
    endtask

    task automatic test_bcd_sweep();
        logic want [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        for (int i = 0; i < 8; i++) begin
            drive(i << 1, 1'b0, 1'b0);
            n_checks++;
            if (bus.m_question !== want[i] || bus.m_answer !== want[i] ||
                bus.mismatch !== 1'b0 || obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL bcd_sweep[%0d]: got %h want %h (mq %b want %b)",
                         i, obs_v, exp_v, bus.m_question, want[i]);
            end
        end
    endtask

    task automatic test_e_only();
        logic [31:0] mask;
        drive(1, 1'b0, 1'b0);
        n_checks++;
        if (bus.m_question !== 1'b1 || bus.m_answer !== 1'b1) begin
            n_fail++;
            $display("FAIL e_only: got mq=%b ma=%b want 1 1", bus.m_question, bus.m_answer);
        end
        // indices applied so far: 16, 0,2,..,14, 1
        mask = 32'h0001_0000 | 32'h2;
        for (int i = 0; i < 8; i++) mask = mask | (32'd1 << (i * 2));
        n_checks++;
        if (bus.coverage !== mask) begin
            n_fail++;
            $display("FAIL partial_coverage: got %h want %h", bus.coverage, mask);
        end
    endtask

    task automatic test_exhaustive();
        for (int i = 0; i < 32; i++) begin
            drive(i, 1'b0, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL exhaustive[%0d]: got %h want %h", i, obs_v, exp_v);
            end
        end
        n_checks++;
        if (bus.coverage !== 32'hFFFF_FFFF || bus.mismatch_count !== '0 ||
            bus.mismatch_sticky !== 1'b0) begin
            n_fail++;
            $display("FAIL full_coverage: got cov=%h cnt=%0d sticky=%b want ffffffff 0 0",
                     bus.coverage, bus.mismatch_count, bus.mismatch_sticky);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            drive(int'($urandom_range(0, 31)), 1'b0, 1'b0);
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h want %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_fault_saturate();
        drive(0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            drive(int'($urandom_range(0, 31)), 1'b0, 1'b1);
            n_checks++;
            if (bus.mismatch !== 1'b1 || obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL fault[%0d]: got %h want %h", i, obs_v, exp_v);
            end
        end
        release dut.n_c;
        n_checks++;
        if (bus.mismatch_count !== 8'd255 || bus.mismatch_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%0d sticky=%b want 255 1",
                     bus.mismatch_count, bus.mismatch_sticky);
        end
        // sticky holds after the fault is gone
        drive(0, 1'b0, 1'b0);
        n_checks++;
        if (bus.mismatch !== 1'b0 || bus.mismatch_sticky !== 1'b1 || obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL sticky_hold: got %h want %h", obs_v, exp_v);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) drive(int'($urandom_range(0, 31)), 1'b0, 1'b0);
        drive(31, 1'b1, 1'b0);
        n_checks++;
        if (obs_v !== {(CNT_W+36){1'b0}}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want 0", obs_v);
        end
        drive(3, 1'b0, 1'b0);
        n_checks++;
        if (bus.coverage !== 32'h0000_0008 || obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset: got cov=%h all=%h want cov=00000008 all=%h",
                     bus.coverage, obs_v, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        {bus.a, bus.b, bus.c, bus.d, bus.e} = 5'b0;
        exp_mq = 0; exp_ma = 0; exp_mm = 0; exp_ms = 0;
        exp_cnt = '0; exp_cov = '0;
        exp_v = '0;
        obs_v = '0;
        test_reset();
        test_bcd_sweep();
        test_e_only();
        test_exhaustive();
        test_random();
        test_fault_saturate();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
